// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared types and byte-lane helpers for the memory-access stage
package mips_cpu_pkg;
  typedef enum logic [3:0] {
    LB = 4'd0, LBU = 4'd1, LH = 4'd2, LHU = 4'd3, LW = 4'd4,
    LWL = 4'd5, LWR = 4'd6, SB = 4'd7, SH = 4'd8, SW = 4'd9
  } mem_op_t;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  function automatic logic is_load(mem_op_t op);
    return op inside {LB, LBU, LH, LHU, LW, LWL, LWR};
  endfunction
  function automatic logic is_store(mem_op_t op);
    return op inside {SB, SH, SW};
  endfunction
  function automatic logic misaligned(mem_op_t op, logic [1:0] off);
    return ((op inside {LH, LHU, SH}) && off[0]) || ((op inside {LW, SW}) && off != 2'd0);
  endfunction
  function automatic logic [3:0] lanes(mem_op_t op, logic [1:0] off);
    return op == SB ? 4'b0001 << off : op == SH ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic logic [31:0] wdata(mem_op_t op, logic [31:0] sd);
    return op == SB ? {4{sd[7:0]}} : op == SH ? {2{sd[15:0]}} : sd;
  endfunction
endpackage

// File: rtl/mips_cpu_load_align.sv
// mips_cpu_load_align: extracts, extends and merges load data from a bus word
module mips_cpu_load_align
  import mips_cpu_pkg::*;
(
  input  mem_op_t     mem_op,
  input  logic [1:0]  offset,
  input  logic [31:0] readdata,
  input  logic [31:0] rt_old,
  output logic [31:0] load_data
);
  logic [15:0] lo;
  logic [4:0] sh, rsh;
  always_comb begin
    sh = {offset, 3'b000};
    rsh = {~offset, 3'b000};
    lo = 16'(readdata >> sh);
    load_data = '0;
    case (mem_op)
      LB:  load_data = {{24{lo[7]}}, lo[7:0]};
      LBU: load_data = {24'd0, lo[7:0]};
      LH:  load_data = {{16{lo[15]}}, lo};
      LHU: load_data = {16'd0, lo};
      LW:  load_data = readdata;
      LWL: load_data = (readdata << rsh) | (rt_old & ~(32'hFFFFFFFF << rsh));
      LWR: load_data = (readdata >> sh) | (rt_old & ~(32'hFFFFFFFF >> sh));
      default: load_data = '0;
    endcase
  end
endmodule

// File: rtl/mips_cpu_mem_access.sv
// mips_cpu_mem_access: one Avalon-MM word access per load/store with stall handling
module mips_cpu_mem_access
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] rt_old,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        addr_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);
  state_t state_q, state_d;
  mem_op_t op_q, op_d, op_in;
  logic [1:0] off_q, off_d;
  logic [31:0] rt_q, rt_d, address_q, address_d, wd_q, wd_d, ld_q, ld_d, aligned;
  logic read_q, read_d, write_q, write_d, err_q, err_d, bad;
  logic [3:0] be_q, be_d;
  mips_cpu_load_align u_align (
    .mem_op(op_q), .offset(off_q), .readdata(readdata), .rt_old(rt_q), .load_data(aligned)
  );
  always_comb begin
    op_in = mem_op_t'(mem_op);
    bad = misaligned(op_in, addr[1:0]);
    state_d = state_q;
    op_d = op_q;
    off_d = off_q;
    rt_d = rt_q;
    address_d = address_q;
    wd_d = wd_q;
    ld_d = ld_q;
    read_d = read_q;
    write_d = write_q;
    be_d = be_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        op_d = op_in;
        off_d = addr[1:0];
        rt_d = rt_old;
        if ((is_load(op_in) || is_store(op_in)) && !bad) begin
          state_d = REQ;
          address_d = {addr[31:2], 2'b00};
          read_d = is_load(op_in);
          write_d = is_store(op_in);
          be_d = lanes(op_in, addr[1:0]);
          wd_d = wdata(op_in, store_data);
        end else begin
          // misaligned and unknown ops complete without touching the bus
          state_d = DONE;
          err_d = bad;
          ld_d = '0;
        end
      end
      REQ: if (!waitrequest) begin
        state_d = DONE;
        read_d = 1'b0;
        write_d = 1'b0;
        be_d = '0;
        ld_d = read_q ? aligned : '0;
      end
      default: begin
        state_d = IDLE;
        err_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q <= LB;
      off_q <= '0;
      rt_q <= '0;
      address_q <= '0;
      wd_q <= '0;
      ld_q <= '0;
      read_q <= 1'b0;
      write_q <= 1'b0;
      be_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      off_q <= off_d;
      rt_q <= rt_d;
      address_q <= address_d;
      wd_q <= wd_d;
      ld_q <= ld_d;
      read_q <= read_d;
      write_q <= write_d;
      be_q <= be_d;
      err_q <= err_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign load_data = ld_q;
  assign addr_error = err_q;
  assign address = address_q;
  assign read = read_q;
  assign write = write_q;
  assign byteenable = be_q;
  assign writedata = wd_q;
endmodule

// File: doc/mips_cpu_mem_access.md
Name: mips_cpu_mem_access

Overview:
Memory-access stage directly downstream of the ALU; consumes the ALU result as an effective byte address.
Issues one Avalon-MM style word access per load/store and handles waitrequest stalls.
Generates byte lanes for stores; aligns and extends load data, including LWL/LWR merges, for the register writeback path.
Raises a one-cycle done pulse to the control FSM.

Parameters:
None (32-bit data and address fixed).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
start  in  1  begin access; sampled only in IDLE
mem_op  in  4  access type (mem_op_t: LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW)
addr  in  32  effective byte address (ALU result)
store_data  in  32  rt value for stores
rt_old  in  32  current rt value, merged by LWL/LWR
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse, access complete
load_data  out  32  aligned/extended load result, valid while done=1
addr_error  out  1  valid with done; misaligned LH/LHU/LW/SH/SW
address  out  32  bus address, word aligned ({addr[31:2],2'b00})
read  out  1  bus read request
write  out  1  bus write request
byteenable  out  4  bus byte lanes
writedata  out  32  bus write data
readdata  in  32  bus read data, valid when read=1 and waitrequest=0
waitrequest  in  1  bus stall

Behaviour:
- Reset (async, reset=0): state IDLE; busy, done, read, write, addr_error=0; byteenable=0; address, writedata, load_data=0. Any in-flight request is dropped immediately, and the access is not retried after reset.
- FSM: IDLE -> REQ (start=1, aligned) | IDLE -> DONE (start=1, misaligned). REQ -> DONE when waitrequest=0. DONE -> IDLE unconditionally.
- start with mem_op outside the enumeration: treated as a no-op. Go to DONE, addr_error=0, load_data=0, no bus cycle.
- On accept: register mem_op, addr[1:0], store_data and rt_old. Inputs may change afterwards.
- busy=1 in REQ and DONE. start while busy is ignored.
- REQ: read or write held high, with address, byteenable and writedata stable, until the waitrequest=0 cycle. Minimum latency start -> done is 2 cycles (REQ one cycle, DONE pulse next).
- readdata is captured on the REQ cycle with waitrequest=0. load_data is registered and presented during DONE; it holds its value afterwards until the next done.
- Little-endian byte lanes; o = addr[1:0].
  - SB: byteenable = 1<<o; writedata = {4{store_data[7:0]}}.
  - SH: byteenable = 0011 (o=0) or 1100 (o=2); writedata = {2{store_data[15:0]}}.
  - SW: byteenable = 1111; writedata = store_data.
  - All loads: byteenable = 1111.
- Load extraction:
  - LB/LBU: byte = readdata[8o+7:8o], sign- or zero-extended.
  - LH/LHU: half = readdata[8o+15:8o], sign- or zero-extended.
  - LW: readdata.
  - LWL: load_data = (readdata << 8*(3-o)) | (rt_old & ((1 << 8*(3-o)) - 1)).
  - LWR: load_data = (readdata >> 8*o) | (rt_old & ~(32'hFFFFFFFF >> 8*o)).
  - LWL/LWR never flag a misalignment.
- Misaligned (LH/LHU/SH with o odd; LW/SW with o!=0): no bus cycle; done=1 with addr_error=1 and load_data=0 one cycle after start.
- Stores: load_data=0 at done.
- Bus outputs are registered; read and write are never high together.

Decomposition:
- mips_cpu_pkg: mem_op_t enum (4-bit), state_t enum (IDLE, REQ, DONE), byte-lane helper functions.
- Natural sub-module: mips_cpu_load_align, purely combinational. Inputs: mem_op, offset, readdata, rt_old. Output: load_data. This keeps the lane logic unit-testable apart from the FSM.

Test Plan:
1. LW addr=0x100, readdata=0xDEADBEEF, waitrequest=0 -> address=0x100, read for 1 cycle, done 2 cycles after start, load_data=0xDEADBEEF.
2. LB addr=0x103, readdata=0x80112233; then LBU at the same address -> LB: load_data=0xFFFFFF80; LBU: load_data=0x00000080.
3. SH addr=0x202, store_data=0x0000ABCD, waitrequest high for 3 cycles -> write held 4 cycles with address=0x200, byteenable=1100, writedata=0xABCDABCD stable; single done pulse.
4. LWL addr=0x301, readdata=0x44332211, rt_old=0xAABBCCDD -> load_data=0x2211CCDD. LWR at the same address and data -> load_data=0xAA443322.
5. LW addr=0x102 -> no read asserted, done+addr_error=1 one cycle after start, load_data=0. start pulsed during busy is ignored.
6. reset driven low mid-REQ with waitrequest=1 -> read=0 and busy=0 immediately (async). After release, state is IDLE and no done pulse occurs.
